// File: rtl/icache_refill_pkg.sv
// Shared constants and state encoding for the instruction-cache refill engine.
package icache_refill_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int BYTE_W      = 8;
  localparam int FILL_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } refill_state_t;

endpackage

// File: rtl/icache_refill.sv
// Instruction-side miss refill: four pipelined byte reads assembled little-endian,
// then a one-cycle cache fill write with the instruction returned to IF.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W     = INST_ADDR_W,
  parameter int WORD_BYTES = FILL_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_grant_i,
  input  logic [7:0]        mem_byte_i,
  output logic              cache_we_o,
  output logic [ADDR_W-1:0] cache_waddr_o,
  output logic [31:0]       cache_winst_o
);

  localparam logic [2:0] LAST_CNT = 3'(WORD_BYTES);

  refill_state_t     state_r;
  refill_state_t     state_next;
  logic [ADDR_W-1:0] base_r;
  logic [2:0]        issue_cnt_r;
  logic [2:0]        recv_cnt_r;
  logic [2:0]        recv_next_s;
  logic [31:0]       word_r;
  logic              pend_r;
  logic              accept_s;
  logic              capture_s;
  logic              start_s;

  // pend_r marks that a byte returns this cycle; only FETCH ever captures it
  assign start_s     = rdy & miss_i & ~flush_i;
  assign accept_s    = mem_req_o & mem_grant_i;
  assign capture_s   = (state_r == ST_FETCH) & pend_r;
  assign recv_next_s = capture_s ? (recv_cnt_r + 3'd1) : recv_cnt_r;

  // Next-state decode and output generation
  always_comb begin
    state_next    = state_r;
    mem_req_o     = 1'b0;
    mem_addr_o    = {ADDR_W{1'b0}};
    cache_we_o    = 1'b0;
    cache_waddr_o = {ADDR_W{1'b0}};
    cache_winst_o = 32'h0000_0000;
    inst_valid_o  = 1'b0;
    inst_o        = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_req_o  = rdy & (issue_cnt_r < LAST_CNT);
        mem_addr_o = base_r + ADDR_W'(issue_cnt_r);
        // with rdy low the last byte may land while held; DONE follows once rdy returns
        if (flush_i) begin
          state_next = ST_IDLE;
        end else if (rdy && (recv_next_s == LAST_CNT)) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (rdy) begin
          cache_we_o    = 1'b1;
          cache_waddr_o = base_r;
          cache_winst_o = word_r;
          inst_valid_o  = ~flush_i;
          inst_o        = word_r;
          state_next    = ST_IDLE;
        end else begin
          state_next    = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters, latched address and assembly register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      base_r      <= {ADDR_W{1'b0}};
      issue_cnt_r <= 3'd0;
      recv_cnt_r  <= 3'd0;
      word_r      <= 32'h0000_0000;
      pend_r      <= 1'b0;
    end else begin
      state_r <= state_next;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            base_r      <= pc_i;
            issue_cnt_r <= 3'd0;
            recv_cnt_r  <= 3'd0;
            word_r      <= 32'h0000_0000;
          end
          pend_r <= 1'b0;
        end
        ST_FETCH: begin
          if (flush_i) begin
            issue_cnt_r <= 3'd0;
            recv_cnt_r  <= 3'd0;
            pend_r      <= 1'b0;
          end else begin
            if (accept_s) begin
              issue_cnt_r <= issue_cnt_r + 3'd1;
            end
            if (capture_s) begin
              word_r[{recv_cnt_r[1:0], 3'b000} +: BYTE_W] <= mem_byte_i;
            end
            recv_cnt_r <= recv_next_s;
            pend_r     <= accept_s;
          end
        end
        default: begin
          pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: byte memory model, per-cycle stimulus masks,
// hand-computed event cycles and words.
module tb_icache_refill;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        miss_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_byte_i;
  logic        cache_we_o;
  logic [31:0] cache_waddr_o;
  logic [31:0] cache_winst_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int          we_cyc, we_cnt, val_cyc, val_cnt;
  logic [31:0] we_word, we_addr, val_word;
  logic [31:0] addr_log [32];
  logic [31:0] req_log;

  icache_refill dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .miss_i       (miss_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_grant_i  (mem_grant_i),
    .mem_byte_i   (mem_byte_i),
    .cache_we_o   (cache_we_o),
    .cache_waddr_o(cache_waddr_o),
    .cache_winst_o(cache_winst_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    case (a)
      32'h0000_1000: byte_at = 8'h13;
      32'h0000_1001: byte_at = 8'h05;
      32'h0000_1002: byte_at = 8'h10;
      32'h0000_1003: byte_at = 8'h00;
      32'h0000_2000: byte_at = 8'h93;
      32'h0000_2001: byte_at = 8'h00;
      32'h0000_2002: byte_at = 8'h10;
      32'h0000_2003: byte_at = 8'h00;
      default:       byte_at = 8'hEE;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // one clock: the fixed-latency memory returns the accepted byte next cycle, else junk
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = mem_req_o & mem_grant_i;
    a   = mem_addr_o;
    @(posedge clk);
    #1;
    mem_byte_i = acc ? byte_at(a) : 8'hEE;
  endtask

  // cycle 0 is the cycle in which miss_i is first presented
  task automatic run_fill(input logic [31:0] pc, input logic [31:0] gnt_low,
                          input logic [31:0] rdy_low, input logic [31:0] flush_m,
                          input int ncyc);
    logic miss_on;
    miss_on = 1'b1;
    we_cyc = -1; we_cnt = 0; val_cyc = -1; val_cnt = 0;
    we_word = 32'h0; we_addr = 32'h0; val_word = 32'h0; req_log = 32'h0;
    for (int n = 0; n < ncyc; n++) begin
      miss_i      = miss_on;
      pc_i        = pc;
      flush_i     = flush_m[n];
      rdy         = ~rdy_low[n];
      mem_grant_i = ~gnt_low[n];
      #2;
      addr_log[n] = mem_addr_o;
      req_log[n]  = mem_req_o;
      if (cache_we_o) begin
        we_cnt++; we_cyc = n; we_word = cache_winst_o; we_addr = cache_waddr_o;
      end
      if (inst_valid_o) begin
        val_cnt++; val_cyc = n; val_word = inst_o;
      end
      if (cache_we_o || flush_i) miss_on = 1'b0;
      tick();
    end
    flush_i = 1'b0;
    miss_i  = miss_on;
  endtask

  initial begin
    int stray;
    rst = 1'b1; rdy = 1'b1; miss_i = 1'b0; pc_i = 32'h0; flush_i = 1'b0;
    mem_grant_i = 1'b1; mem_byte_i = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_req", {31'h0, mem_req_o}, 32'h0);
    check("rst_maddr", mem_addr_o, 32'h0);
    check("rst_we", {31'h0, cache_we_o}, 32'h0);
    check("rst_waddr", cache_waddr_o, 32'h0);
    check("rst_winst", cache_winst_o, 32'h0);

    // flush beats miss in IDLE
    miss_i = 1'b1; pc_i = 32'h0000_1000; flush_i = 1'b1;
    tick();
    miss_i = 1'b0; flush_i = 1'b0;
    #2;
    check("flush_prio_req", {31'h0, mem_req_o}, 32'h0);

    // basic fill, continuous grant
    run_fill(32'h0000_1000, 32'h0, 32'h0, 32'h0, 9);
    for (int k = 1; k <= 4; k++) begin
      check("basic_addr", addr_log[k], 32'h0000_1000 + 32'(k - 1));
    end
    check("basic_req_mask", req_log & 32'h1FF, 32'h0000_001E);
    check("basic_we_cyc", 32'(we_cyc), 32'd6);
    check("basic_we_cnt", 32'(we_cnt), 32'd1);
    check("basic_waddr", we_addr, 32'h0000_1000);
    check("basic_winst", we_word, 32'h0010_0513);
    check("basic_val_cyc", 32'(val_cyc), 32'd6);
    check("basic_val_cnt", 32'(val_cnt), 32'd1);
    check("basic_inst", val_word, 32'h0010_0513);

    // grant low in cycles 3 and 4: 0x1002 presented three times
    run_fill(32'h0000_1000, 32'h0000_0018, 32'h0, 32'h0, 11);
    check("gnt_addr3", addr_log[3], 32'h0000_1002);
    check("gnt_addr4", addr_log[4], 32'h0000_1002);
    check("gnt_addr5", addr_log[5], 32'h0000_1002);
    check("gnt_addr6", addr_log[6], 32'h0000_1003);
    check("gnt_we_cyc", 32'(we_cyc), 32'd8);
    check("gnt_word", we_word, 32'h0010_0513);
    check("gnt_inst", val_word, 32'h0010_0513);

    // flush in cycle 3, then a new miss at 0x2000 immediately after
    run_fill(32'h0000_1000, 32'h0, 32'h0, 32'h0000_0008, 4);
    check("flush_we_cnt", 32'(we_cnt), 32'd0);
    check("flush_val_cnt", 32'(val_cnt), 32'd0);
    run_fill(32'h0000_2000, 32'h0, 32'h0, 32'h0, 9);
    check("refill_addr1", addr_log[1], 32'h0000_2000);
    check("refill_we_cyc", 32'(we_cyc), 32'd6);
    check("refill_we_cnt", 32'(we_cnt), 32'd1);
    check("refill_waddr", we_addr, 32'h0000_2000);
    check("refill_word", we_word, 32'h0010_0093);
    check("refill_inst", val_word, 32'h0010_0093);

    // flush coincident with DONE: write happens, valid suppressed
    run_fill(32'h0000_1000, 32'h0, 32'h0, 32'h0000_0040, 9);
    check("fdone_we_cyc", 32'(we_cyc), 32'd6);
    check("fdone_word", we_word, 32'h0010_0513);
    check("fdone_val_cnt", 32'(val_cnt), 32'd0);

    // rdy low in cycles 3..5: no requests, completion three cycles late
    run_fill(32'h0000_1000, 32'h0, 32'h0000_0038, 32'h0, 12);
    check("rdy_req_mask", req_log & 32'h0000_0038, 32'h0);
    check("rdy_addr6", addr_log[6], 32'h0000_1002);
    check("rdy_we_cyc", 32'(we_cyc), 32'd9);
    check("rdy_val_cyc", 32'(val_cyc), 32'd9);
    check("rdy_word", we_word, 32'h0010_0513);

    // reset during FETCH
    run_fill(32'h0000_1000, 32'h0, 32'h0, 32'h0, 3);
    miss_i = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("frst_req", {31'h0, mem_req_o}, 32'h0);
    check("frst_maddr", mem_addr_o, 32'h0);
    check("frst_we", {31'h0, cache_we_o}, 32'h0);
    check("frst_valid", {31'h0, inst_valid_o}, 32'h0);
    stray = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      #2;
      if (cache_we_o || inst_valid_o || mem_req_o) stray++;
    end
    check("frst_quiet", 32'(stray), 32'd0);

    // recovery fill after reset
    run_fill(32'h0000_2000, 32'h0, 32'h0, 32'h0, 9);
    check("post_we_cyc", 32'(we_cyc), 32'd6);
    check("post_word", we_word, 32'h0010_0093);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
